// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multichannel PWM block.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam int unsigned DEF_NUM_CH = 16;
    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned DEF_PRE_W  = 4;

    // Channel-index width, never below one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_multichannel_if.sv
// Configuration and duty-write bus from the register file into the PWM block.
interface pwm_multichannel_if #(
    parameter int unsigned NUM_CH = pwm_pkg::DEF_NUM_CH,
    parameter int unsigned CNT_W  = pwm_pkg::DEF_CNT_W,
    parameter int unsigned PRE_W  = pwm_pkg::DEF_PRE_W
);
    localparam int unsigned CH_W = pwm_pkg::ch_width(NUM_CH);

    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic              duty_wr;
    logic [CH_W-1:0]   duty_wr_ch;
    logic [CNT_W-1:0]  duty_wr_data;
    logic [CNT_W-1:0]  period;
    logic [PRE_W-1:0]  prescale;
    logic              center;

    modport master (
        output en_out, en_pwm, duty_wr, duty_wr_ch, duty_wr_data, period, prescale, center
    );

    modport slave (
        input en_out, en_pwm, duty_wr, duty_wr_ch, duty_wr_data, period, prescale, center
    );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty, compare against the shared counter, gated output.
module pwm_channel #(
    parameter int unsigned CNT_W = pwm_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en_out,
    input  logic             en_pwm,
    output logic             out
);

    logic [CNT_W-1:0] duty_pend_q;
    logic [CNT_W-1:0] duty_act_q;
    logic             raw;
    logic             out_d;

    always_comb begin
        raw   = (cnt < duty_act_q);
        out_d = en_out ? (en_pwm ? raw : 1'b1) : 1'b0;
    end

    // load samples the old pending value, so a coincident write waits one more period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_pend_q <= '0;
            duty_act_q  <= '0;
            out         <= 1'b0;
        end else begin
            if (wr_en) begin
                duty_pend_q <= wr_data;
            end
            if (load) begin
                duty_act_q <= duty_pend_q;
            end
            out <= out_d;
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: shared prescaler and up/up-down counter, shadowed period/mode, NUM_CH channels.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned PRE_W  = DEF_PRE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_multichannel_if.slave  cfg,
    output logic [NUM_CH-1:0]  out,
    output logic               period_tick
);

    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] p_act_q;
    pwm_dir_e         dir_q;
    pwm_mode_e        mode_q;
    logic             tick;
    logic             boundary;

    always_comb begin
        tick     = (pre_cnt_q >= cfg.prescale);
        boundary = 1'b0;
        if (tick) begin
            if (p_act_q == '0) begin
                boundary = 1'b1;
            end else if (mode_q == PWM_EDGE) begin
                boundary = (cnt_q == p_act_q);
            end else begin
                boundary = (cnt_q == CNT_W'(1)) && (dir_q == DIR_DOWN);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else if (tick) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_q + 1'b1;
        end
    end

    // dir tracks the direction of the next step, so it is already DOWN while sitting at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            p_act_q     <= '1;
            mode_q      <= PWM_EDGE;
            period_tick <= 1'b0;
        end else begin
            period_tick <= boundary;
            if (boundary) begin
                cnt_q   <= '0;
                dir_q   <= DIR_UP;
                p_act_q <= cfg.period;
                mode_q  <= pwm_mode_e'(cfg.center);
            end else if (tick) begin
                if (mode_q == PWM_EDGE) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (dir_q == DIR_UP) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == p_act_q) begin
                        dir_q <= DIR_DOWN;
                    end
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    // Channel decode only matches existing channels, so out-of-range indices are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;
        assign wr_en = cfg.duty_wr && (cfg.duty_wr_ch == CH_W'(i));

        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (boundary),
            .wr_en   (wr_en),
            .wr_data (cfg.duty_wr_data),
            .cnt     (cnt_q),
            .en_out  (cfg.en_out[i]),
            .en_pwm  (cfg.en_pwm[i]),
            .out     (out[i])
        );
    end

endmodule
